stage_if_pf: RTL and testbench

Prefetching instruction-fetch stage: the parametrised successor to the single-cycle fetch stage, for memories with variable read latency and a request/grant handshake. Keeps up to DEPTH requests in flight, buffers returned instructions in a prefetch FIFO, and holds its output while decode stalls. On an EX-stage branch it redirects, flushing buffered and in-flight fetches. Sits between the instruction memory port and the decode stage, driving `if_out_t`.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/stage_if_pf.sv | 132 +++++++++++++
 tb/tb_stage_if_pf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types for the fetch/decode/execute stages
//
// Purpose : stage-to-stage structs used across the pipeline plus small
//           PC helpers shared by the fetch logic.
// Contents: if_out_t      fetch -> decode  {pc, nextpc, instr, bubble}
//           ex_out_t      execute -> fetch {branch, branch_dest}
//           fetch_entry_t prefetch buffer entry {pc, instr}
package pipeline_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] instr;
    logic        bubble;
  } if_out_t;

  typedef struct packed {
    logic        branch;
    logic [31:0] branch_dest;
  } ex_out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with wrap-bit pointers
//
// Purpose : holds returned instructions until decode consumes them.
// Params  : DEPTH   entries (power of two, >= 2)
//           entry_t stored element type
// Ports   : clk, rst        clock, synchronous active-high reset
//           push, push_data write request and data
//           pop             remove head entry (ignored when empty)
//           flush           empty the FIFO; wins over push and pop
//           count           current occupancy
//           head            oldest entry (undefined when empty)
//           empty           no entries
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     head,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH+1);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   w_diff;
  logic            w_full;
  logic            w_do_push;
  logic            w_do_pop;

  // Pointers carry one extra wrap bit: equal addresses with differing wrap
  // bits mean full, fully equal pointers mean empty.
  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign count     = CW'(w_diff);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!w_full || w_do_pop);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush && !rst) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

  // Upstream credit accounting must never let a push hit a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && w_full && !w_do_pop));
  end

endmodule

// File: rtl/stage_if_pf.sv
// rtl/stage_if_pf.sv - prefetching instruction fetch stage
//
// Purpose : issues word fetches with a req/gnt handshake, keeps up to DEPTH
//           requests outstanding or buffered, returns instructions to decode
//           in order, and redirects on an EX-stage branch, dropping stale
//           in-flight responses.
// Config  : IF_PF_BYPASS_EN - when defined, a kept response arriving at an
//           empty FIFO drives out combinationally in the same cycle.
// Params  : DEPTH (power of two, >= 2), RESET_PC
// Ports   : clk, rst     clock, synchronous active-high reset
//           stall        decode cannot accept out this cycle
//           EX           branch / branch_dest from execute
//           out          pc, nextpc, instr, bubble to decode
//           mem_req      fetch request valid
//           mem_addr     fetch address (word aligned)
//           mem_gnt      request accepted this cycle
//           mem_rvalid   response valid (in request order)
//           mem_rdata    response instruction
module stage_if_pf
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  ex_out_t     EX,
  output if_out_t     out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_empty;
  logic [CW:0]   w_credit_sum;
  logic          w_gnt;
  logic          w_keep;
  logic          w_push;
  logic          w_pop;
  logic          w_bubble;
  logic [31:0]   w_out_pc;
  logic [31:0]   w_out_instr;
  logic [31:0]   w_target;

  assign w_target = word_align(EX.branch_dest);

  // Credit covers buffered entries plus kept in-flight requests; responses
  // already marked for discard never land in the FIFO so they are excluded.
  assign w_credit_sum = {1'b0, w_count} + {1'b0, r_inflight};
  assign mem_req      = !rst && !EX.branch && (w_credit_sum < (CW+1)'(DEPTH));
  assign mem_addr     = r_fetch_pc;
  assign w_gnt        = mem_req && mem_gnt;
  assign w_keep       = mem_rvalid && (r_discard == '0);

`ifdef IF_PF_BYPASS_EN
  logic w_bypass;
  // A kept response meeting an empty FIFO goes straight to decode; it is
  // only buffered when decode stalls.
  assign w_bypass    = w_keep && w_empty && !EX.branch && !rst;
  assign w_out_pc    = w_bypass ? r_resp_pc : w_head.pc;
  assign w_out_instr = w_bypass ? mem_rdata : w_head.instr;
  assign w_bubble    = rst || EX.branch || (w_empty && !w_bypass);
  assign w_push      = w_keep && !EX.branch && !(w_bypass && !stall);
`else
  assign w_out_pc    = w_head.pc;
  assign w_out_instr = w_head.instr;
  assign w_bubble    = rst || EX.branch || w_empty;
  assign w_push      = w_keep && !EX.branch;
`endif

  // Bypassed words are consumed with the FIFO empty, so popping only ever
  // applies to a real head entry.
  assign w_pop = !w_bubble && !stall && !w_empty;

  assign w_push_entry.pc    = r_resp_pc;
  assign w_push_entry.instr = mem_rdata;

  assign out.pc     = w_out_pc;
  assign out.nextpc = w_out_pc + PC_STEP;
  assign out.instr  = w_out_instr;
  assign out.bubble = w_bubble;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (EX.branch),
    .count     (w_count),
    .head      (w_head),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else if (EX.branch) begin
      // Everything still outstanding becomes stale. A response arriving this
      // cycle is retired from whichever counter currently owns it.
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
      r_inflight <= '0;
      r_discard  <= r_discard + r_inflight - CW'(mem_rvalid);
    end else begin
      if (w_gnt)  r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_keep) r_resp_pc  <= r_resp_pc + PC_STEP;
      r_inflight <= r_inflight + CW'(w_gnt) - CW'(w_keep);
      if (mem_rvalid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
    end
  end

endmodule

// File: tb/tb_stage_if_pf.sv
// tb/tb_stage_if_pf.sv - self-checking bench for stage_if_pf
module tb_stage_if_pf;
  import pipeline_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  ex_out_t     ex;
  if_out_t     out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  stage_if_pf #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .EX         (ex),
    .out        (out),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rc = 0;

  // memory side: accepted addresses with the cycle their response is due
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due = 0;
  int          lat_min = 2;
  int          lat_max = 2;
  int          gnt_pct = 100;

  // reference model: delivered-but-unconsumed PCs and outstanding counts
  logic [31:0] m_q[$];
  int          m_kept = 0;
  int          m_stale = 0;
  logic [31:0] m_fetch;
  logic [31:0] m_resp;

  int          first_valid_rc = -1;
  logic [31:0] after_br_pcs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle();
    logic        rv;
    logic [31:0] raddr;
    logic        keep, byp, exp_req, exp_bub;
    logic [31:0] head_pc;
    int          due;
    rv = 1'b0;
    raddr = '0;
    if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      rv = 1'b1;
      raddr = pend_addr.pop_front();
      void'(pend_due.pop_front());
    end
    mem_rvalid = rv;
    mem_rdata  = rv ? mem_word(raddr) : 32'hDEAD_BEEF;
    mem_gnt    = (pend_addr.size() < DEPTH) && ($urandom_range(99) < gnt_pct);
    #1;
    if (rst) begin
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_bubble", out.bubble, 1'b1);
      m_q.delete();
      m_kept = 0;
      m_stale = 0;
      m_fetch = RST_PC;
      m_resp = RST_PC;
      pend_addr.delete();
      pend_due.delete();
      last_due = 0;
      rc = 0;
    end else begin
      keep = rv && (m_stale == 0);
      exp_req = !ex.branch && (m_q.size() + m_kept < DEPTH);
`ifdef IF_PF_BYPASS_EN
      byp = keep && (m_q.size() == 0) && !ex.branch;
`else
      byp = 1'b0;
`endif
      exp_bub = ex.branch || ((m_q.size() == 0) && !byp);
      check("mem_req", mem_req, exp_req);
      if (exp_req) check("mem_addr", mem_addr, m_fetch);
      check("bubble", out.bubble, exp_bub);
      if (!exp_bub) begin
        head_pc = byp ? m_resp : m_q[0];
        check("out_pc", out.pc, head_pc);
        check("out_instr", out.instr, mem_word(head_pc));
        check("out_nextpc", out.nextpc, head_pc + 32'd4);
        if (first_valid_rc < 0) first_valid_rc = rc;
        if (!stall) after_br_pcs.push_back(head_pc);
      end
      if (mem_req && mem_gnt) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(mem_addr);
        pend_due.push_back(due);
      end
      if (ex.branch) begin
        m_q.delete();
        m_stale = m_stale + m_kept - (rv ? 1 : 0);
        m_kept = 0;
        m_fetch = {ex.branch_dest[31:2], 2'b00};
        m_resp = m_fetch;
        after_br_pcs.delete();
      end else begin
        if (rv) begin
          if (m_stale > 0) m_stale--;
          else begin
            m_kept--;
            m_q.push_back(m_resp);
            m_resp = m_resp + 32'd4;
          end
        end
        if (!exp_bub && !stall) void'(m_q.pop_front());
        if (exp_req && mem_gnt) begin
          m_kept++;
          m_fetch = m_fetch + 32'd4;
        end
      end
      rc++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    stall = 1'b0;
    ex = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    repeat (3) do_cycle();

    // sequential stream, gnt tied high, latency 2
    rst = 1'b0;
    first_valid_rc = -1;
    #1;
    check("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, 32'h0000_0100);
    repeat (12) do_cycle();
`ifdef IF_PF_BYPASS_EN
    check("first_valid_cycle", first_valid_rc, 32'd2);
`else
    check("first_valid_cycle", first_valid_rc, 32'd3);
`endif

    // decode stall: credit must throttle requests
    stall = 1'b1;
    repeat (6) do_cycle();
    #1;
    check("stall_req_drop", mem_req, 1'b0);
    stall = 1'b0;
    repeat (10) do_cycle();

    // branch with requests in flight
    lat_min = 3;
    lat_max = 3;
    repeat (8) do_cycle();
    ex.branch = 1'b1;
    ex.branch_dest = 32'h0000_2003;
    do_cycle();
    ex = '0;
    #1;
    check("br_req", mem_req, 1'b1);
    check("br_addr", mem_addr, 32'h0000_2000);
    repeat (12) do_cycle();
    check("br_first_cnt", after_br_pcs.size() > 0, 1'b1);
    if (after_br_pcs.size() > 0) check("br_first_pc", after_br_pcs[0], 32'h0000_2000);

    // branch coinciding with stall and a response
    stall = 1'b1;
    guard = 0;
    while (!(pend_due.size() > 0 && pend_due[0] <= cyc) && guard < 20) begin
      do_cycle();
      guard++;
    end
    check("brstall_setup", guard < 20, 1'b1);
    ex.branch = 1'b1;
    ex.branch_dest = 32'h0000_3000;
    do_cycle();
    ex = '0;
    #1;
    check("brstall_bubble", out.bubble, 1'b1);
    stall = 1'b0;
    repeat (12) do_cycle();
    check("brstall_cnt", after_br_pcs.size() > 0, 1'b1);
    if (after_br_pcs.size() > 0) check("brstall_pc", after_br_pcs[0], 32'h0000_3000);

    // PC wrap at the top of the address space
    lat_min = 2;
    lat_max = 2;
    ex.branch = 1'b1;
    ex.branch_dest = 32'hFFFF_FFF8;
    do_cycle();
    ex = '0;
    repeat (12) do_cycle();
    check("wrap_cnt", after_br_pcs.size() >= 3, 1'b1);
    if (after_br_pcs.size() >= 3) begin
      check("wrap_pc0", after_br_pcs[0], 32'hFFFF_FFF8);
      check("wrap_pc1", after_br_pcs[1], 32'hFFFF_FFFC);
      check("wrap_pc2", after_br_pcs[2], 32'h0000_0000);
    end

    // randomized grant, latency, stall and branches against the model
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(99) < 25);
      ex.branch = ($urandom_range(99) < 3);
      ex.branch_dest = $urandom();
      do_cycle();
    end
    ex = '0;
    stall = 1'b0;
    repeat (20) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
